// File: rtl/cpu_run_controller.sv
// ---------------------------------------------------------------------------
// cpu_run_controller
//
// Sequences one run of a single-cycle CPU core. It holds the core in reset
// for a programmable number of cycles and then lets it execute. While the
// core runs, the controller counts cycles and retired (non-NOP)
// instructions. The run ends when the program counter stops moving, which
// is treated as a halt, or when the cycle budget is used up, which is
// treated as a timeout. The result flags and counters are then held until
// the next start request.
//
// Ports
//   clk        in   rising-edge system clock
//   rst        in   synchronous active-low reset
//   start      in   one-cycle run request (honoured in IDLE, HALT, TIMEOUT)
//   pc         in   core program counter          [ADDR_LEN-1:0]
//   inst       in   core current instruction      [INSTR_LEN-1:0]
//   cpu_rst    out  active-high reset to the core
//   running    out  high while the core is running
//   done       out  sticky: run finished (halt or timeout)
//   halted     out  sticky: run ended by a pc self-loop
//   timeout    out  sticky: run ended by the cycle budget
//   cycle_cnt  out  cycles spent in the current/last run [CNT_W-1:0]
//   instr_cnt  out  run cycles with inst != NOP_INST    [CNT_W-1:0]
//   last_pc    out  pc seen on the most recent run cycle [ADDR_LEN-1:0]
// ---------------------------------------------------------------------------
module cpu_run_controller #(
    parameter int                   ADDR_LEN     = 32,
    parameter int                   INSTR_LEN    = 32,
    parameter int                   CNT_W        = 16,
    parameter int                   RESET_CYCLES = 1,
    parameter int                   MAX_CYCLES   = 20,
    parameter int                   HALT_REPEAT  = 2,
    parameter logic [INSTR_LEN-1:0] NOP_INST     = {INSTR_LEN{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_LEN-1:0]  pc,
    input  logic [INSTR_LEN-1:0] inst,
    output logic                 cpu_rst,
    output logic                 running,
    output logic                 done,
    output logic                 halted,
    output logic                 timeout,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instr_cnt,
    output logic [ADDR_LEN-1:0]  last_pc
);

    // The reset counter only has to count from 0 to RESET_CYCLES-1.
    localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    // The stall counter only has to count from 0 to HALT_REPEAT.
    localparam int SCW = (HALT_REPEAT > 0) ? $clog2(HALT_REPEAT + 1) : 1;

    localparam logic [RCW-1:0]   RST_LAST  = RCW'(RESET_CYCLES - 1);
    localparam logic [SCW-1:0]   HALT_CMP  = SCW'(HALT_REPEAT);
    localparam logic [CNT_W-1:0] MAX_CMP   = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_HALT,
        S_TIMEOUT
    } state_e;

    state_e               state_q,     state_d;
    logic                 cpu_rst_q,   cpu_rst_d;
    logic                 running_q,   running_d;
    logic                 done_q,      done_d;
    logic                 halted_q,    halted_d;
    logic                 timeout_q,   timeout_d;
    logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]     instr_cnt_q, instr_cnt_d;
    logic [ADDR_LEN-1:0]  last_pc_q,   last_pc_d;
    logic [RCW-1:0]       rst_cnt_q,   rst_cnt_d;
    logic [SCW-1:0]       stall_cnt_q, stall_cnt_d;

    // Helper values for the RUN state, computed unconditionally so the
    // next-state process stays a flat decision tree.
    logic [CNT_W-1:0]     cycle_inc;
    logic [CNT_W-1:0]     instr_inc;
    logic [SCW-1:0]       stall_next;
    logic                 first_run_cycle;
    logic                 halt_hit;
    logic                 budget_hit;

    // Saturating increments, and the stall count this RUN edge would produce.
    // The cycle counter is zero only on the first RUN cycle of a run because
    // it is cleared when the run is requested and increments on every RUN
    // edge; on that first cycle last_pc does not belong to this run, so it
    // must not be compared against.
    always_comb begin
        cycle_inc       = (cycle_cnt_q == CNT_SAT) ? cycle_cnt_q
                                                   : cycle_cnt_q + CNT_W'(1);
        instr_inc       = (instr_cnt_q == CNT_SAT) ? instr_cnt_q
                                                   : instr_cnt_q + CNT_W'(1);
        first_run_cycle = (cycle_cnt_q == '0);
        if (first_run_cycle) begin
            stall_next = '0;
        end else if (pc == last_pc_q) begin
            stall_next = stall_cnt_q + SCW'(1);
        end else begin
            stall_next = '0;
        end
        halt_hit   = (stall_next == HALT_CMP);
        budget_hit = (cycle_inc == MAX_CMP);
    end

    // Next-state and next-output logic. Every register holds by default;
    // outputs are derived from the state being entered so that they change
    // on the same edge as the state itself.
    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        halted_d    = halted_q;
        timeout_d   = timeout_q;
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        last_pc_d   = last_pc_q;
        rst_cnt_d   = rst_cnt_q;
        stall_cnt_d = stall_cnt_q;

        unique case (state_q)
            S_IDLE, S_HALT, S_TIMEOUT: begin
                if (start) begin
                    state_d     = S_RESET;
                    done_d      = 1'b0;
                    halted_d    = 1'b0;
                    timeout_d   = 1'b0;
                    cycle_cnt_d = '0;
                    instr_cnt_d = '0;
                    last_pc_d   = '0;
                    rst_cnt_d   = '0;
                    stall_cnt_d = '0;
                end
            end

            S_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
            end

            S_RUN: begin
                cycle_cnt_d = cycle_inc;
                last_pc_d   = pc;
                stall_cnt_d = stall_next;
                if (inst != NOP_INST) begin
                    instr_cnt_d = instr_inc;
                end
                // A halt on the last budgeted cycle is still reported as a
                // halt, since the program did reach its end.
                if (halt_hit) begin
                    state_d  = S_HALT;
                    done_d   = 1'b1;
                    halted_d = 1'b1;
                end else if (budget_hit) begin
                    state_d   = S_TIMEOUT;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cpu_rst_d = (state_d != S_RUN);
        running_d = (state_d == S_RUN);
    end

    // State and output registers with synchronous active-low reset. A reset
    // in the middle of a run simply abandons it without setting any flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cpu_rst_q   <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
            last_pc_q   <= '0;
            rst_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_rst_q   <= cpu_rst_d;
            running_q   <= running_d;
            done_q      <= done_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
            last_pc_q   <= last_pc_d;
            rst_cnt_q   <= rst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign running   = running_q;
    assign done      = done_q;
    assign halted    = halted_q;
    assign timeout   = timeout_q;
    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
    assign last_pc   = last_pc_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_controller
//
// Drives cpu_run_controller through directed runs (timeout with NOPs,
// restart into a halt, halt coinciding with the budget, reset in mid-run)
// and then through random start/reset/pc/inst traffic. A run-level model
// keeps the list of pcs seen in the current run and derives every output
// from that list each cycle.
// ---------------------------------------------------------------------------
module tb_cpu_run_controller;

    localparam int          ADDR_LEN     = 32;
    localparam int          INSTR_LEN    = 32;
    localparam int          CNT_W        = 16;
    localparam int          RESET_CYCLES = 3;
    localparam int          MAX_CYCLES   = 10;
    localparam int          HALT_REPEAT  = 2;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] ALU_INST     = 32'h0000_0013;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b0;
    logic                 start = 1'b0;
    logic [ADDR_LEN-1:0]  pc    = '0;
    logic [INSTR_LEN-1:0] inst  = '0;
    logic                 cpu_rst;
    logic                 running;
    logic                 done;
    logic                 halted;
    logic                 timeout;
    logic [CNT_W-1:0]     cycle_cnt;
    logic [CNT_W-1:0]     instr_cnt;
    logic [ADDR_LEN-1:0]  last_pc;

    int total = 0;
    int bad   = 0;

    cpu_run_controller #(
        .ADDR_LEN    (ADDR_LEN),
        .INSTR_LEN   (INSTR_LEN),
        .CNT_W       (CNT_W),
        .RESET_CYCLES(RESET_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .HALT_REPEAT (HALT_REPEAT),
        .NOP_INST    (NOP_INST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pc       (pc),
        .inst     (inst),
        .cpu_rst  (cpu_rst),
        .running  (running),
        .done     (done),
        .halted   (halted),
        .timeout  (timeout),
        .cycle_cnt(cycle_cnt),
        .instr_cnt(instr_cnt),
        .last_pc  (last_pc)
    );

    always #5 clk = ~clk;

    // Run-level model: which phase the run is in, how many reset cycles are
    // left, and the history of pcs and retired instructions of this run.
    localparam int P_IDLE = 0, P_RESET = 1, P_RUN = 2, P_HALT = 3, P_TIMEOUT = 4;
    int          mPhase    = P_IDLE;
    int          mRstLeft  = 0;
    logic [31:0] mPcs[$];
    int          mNonNop   = 0;
    bit          mHalted   = 1'b0;
    bit          mTimedOut = 1'b0;
    bit          modelValid = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit s, input logic [31:0] p,
                                 input logic [31:0] i, input bit r);
        @(negedge clk);
        start = s;
        pc    = p;
        inst  = i;
        rst   = r;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic clearRun();
        mPcs.delete();
        mNonNop   = 0;
        mHalted   = 1'b0;
        mTimedOut = 1'b0;
    endtask

    // Number of pcs at the end of the run history equal to their predecessor.
    function automatic int trailingRepeats();
        int n = 0;
        for (int i = mPcs.size() - 1; i > 0; i--) begin
            if (mPcs[i] == mPcs[i-1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic modelStep();
        if (!rst) begin
            mPhase     = P_IDLE;
            clearRun();
            modelValid = 1'b1;
        end else begin
            case (mPhase)
                P_IDLE, P_HALT, P_TIMEOUT: begin
                    if (start) begin
                        mPhase   = P_RESET;
                        mRstLeft = RESET_CYCLES;
                        clearRun();
                    end
                end
                P_RESET: begin
                    mRstLeft--;
                    if (mRstLeft == 0) mPhase = P_RUN;
                end
                P_RUN: begin
                    mPcs.push_back(pc);
                    if (inst != NOP_INST) mNonNop++;
                    if (trailingRepeats() >= HALT_REPEAT) begin
                        mPhase  = P_HALT;
                        mHalted = 1'b1;
                    end else if (mPcs.size() >= MAX_CYCLES) begin
                        mPhase    = P_TIMEOUT;
                        mTimedOut = 1'b1;
                    end
                end
                default: mPhase = P_IDLE;
            endcase
        end
    endtask

    // Every cycle: advance the model on the edge, then compare all outputs.
    initial begin
        forever begin
            int expCycles;
            @(posedge clk);
            modelStep();
            #1;
            if (modelValid) begin
                expCycles = (mPcs.size() > 65535) ? 65535 : mPcs.size();
                checkOutput("cpu_rst",   cpu_rst,   mPhase != P_RUN);
                checkOutput("running",   running,   mPhase == P_RUN);
                checkOutput("done",      done,      mHalted || mTimedOut);
                checkOutput("halted",    halted,    mHalted);
                checkOutput("timeout",   timeout,   mTimedOut);
                checkOutput("cycle_cnt", cycle_cnt, expCycles);
                checkOutput("instr_cnt", instr_cnt, mNonNop);
                checkOutput("last_pc",   last_pc,   (mPcs.size() > 0) ? mPcs[$] : 32'h0);
            end
        end
    end

    // Start request followed by the reset cycles; start may be held high
    // during RESET to show it is ignored there.
    task automatic startRun(input bit noisyStart);
        applyStimulus(1'b1, 32'h0, ALU_INST, 1'b1);
        repeat (RESET_CYCLES) applyStimulus(noisyStart, 32'h0, ALU_INST, 1'b1);
    endtask

    initial begin
        int runCnt;
        int rstCnt;
        logic [31:0] p;

        // Reset state
        settle();
        checkOutput("reset_cpu_rst", cpu_rst, 1);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_cycle_cnt", cycle_cnt, 0);
        applyStimulus(1'b0, 32'h0, ALU_INST, 1'b1);

        // Timeout run with NOPs on 3 of the 10 budgeted cycles
        startRun(1'b0);
        runCnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            runCnt += running;
            start = 1'b0;
            pc    = 32'd100 + 32'(4 * k);
            inst  = (k == 2 || k == 5 || k == 8) ? NOP_INST : ALU_INST + 32'(k);
        end
        settle();
        checkOutput("to_running_cycles", runCnt, 10);
        checkOutput("to_timeout", timeout, 1);
        checkOutput("to_done", done, 1);
        checkOutput("to_halted", halted, 0);
        checkOutput("to_cycle_cnt", cycle_cnt, 10);
        checkOutput("to_instr_cnt", instr_cnt, 7);
        checkOutput("to_last_pc", last_pc, 136);
        checkOutput("to_cpu_rst", cpu_rst, 1);

        // Restart from TIMEOUT, then halt on pc 0,4,8,8,8
        applyStimulus(1'b1, 32'h0, ALU_INST, 1'b1);
        settle();
        checkOutput("rs_done_cleared", done, 0);
        checkOutput("rs_timeout_cleared", timeout, 0);
        checkOutput("rs_cycle_cleared", cycle_cnt, 0);
        rstCnt = 0;
        for (int k = 0; k <= RESET_CYCLES; k++) begin
            @(negedge clk);
            rstCnt += cpu_rst;
            start = 1'b0;
            pc    = 32'h0;
            inst  = ALU_INST;
        end
        applyStimulus(1'b0, 32'd4, ALU_INST, 1'b1);
        applyStimulus(1'b0, 32'd8, ALU_INST, 1'b1);
        applyStimulus(1'b0, 32'd8, ALU_INST, 1'b1);
        applyStimulus(1'b0, 32'd8, ALU_INST, 1'b1);
        settle();
        checkOutput("rs_cpu_rst_cycles", rstCnt, 3);
        checkOutput("ht_halted", halted, 1);
        checkOutput("ht_done", done, 1);
        checkOutput("ht_timeout", timeout, 0);
        checkOutput("ht_cycle_cnt", cycle_cnt, 5);
        checkOutput("ht_last_pc", last_pc, 8);
        checkOutput("ht_cpu_rst", cpu_rst, 1);
        checkOutput("ht_running", running, 0);

        // Halt on the very cycle the budget runs out
        startRun(1'b0);
        for (int k = 0; k < 10; k++) begin
            p = (k < 8) ? 32'd200 + 32'(4 * k) : 32'd228;
            applyStimulus(1'b0, p, ALU_INST, 1'b1);
        end
        settle();
        checkOutput("co_halted", halted, 1);
        checkOutput("co_timeout", timeout, 0);
        checkOutput("co_cycle_cnt", cycle_cnt, 10);

        // Reset mid-run at cycle_cnt=7, with start noise during RESET/RUN
        startRun(1'b1);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(k[0], 32'd300 + 32'(4 * k), ALU_INST, 1'b1);
        end
        settle();
        checkOutput("mr_cycle_cnt", cycle_cnt, 7);
        checkOutput("mr_running", running, 1);
        applyStimulus(1'b0, 32'd400, ALU_INST, 1'b0);
        settle();
        checkOutput("mr_cpu_rst", cpu_rst, 1);
        checkOutput("mr_running_clr", running, 0);
        checkOutput("mr_flags", {done, halted, timeout}, 0);
        checkOutput("mr_cycle_clr", cycle_cnt, 0);
        checkOutput("mr_instr_clr", instr_cnt, 0);
        checkOutput("mr_last_pc_clr", last_pc, 0);
        applyStimulus(1'b0, 32'h0, ALU_INST, 1'b1);

        // Random traffic
        p = 32'h0;
        repeat (800) begin
            bit r, s;
            logic [31:0] i;
            r = ($urandom_range(0, 59) != 0);
            s = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 2) != 0) p = 32'(4 * $urandom_range(0, 15));
            i = ($urandom_range(0, 3) == 0) ? NOP_INST : $urandom;
            applyStimulus(s, p, i, r);
        end
        applyStimulus(1'b0, 32'h0, ALU_INST, 1'b1);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
